memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: bus-wait cycles per beat before timeout fault.
REQ-002 SHALL take data width XLEN from `BIT_COUNT` (32 or 64); BYTES = XLEN/8.
REQ-003 SHALL use one clock and synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 MemEn  in  1  memory instruction present in M stage.
REQ-006 MemWrite  in  1  1=store, 0=load.
REQ-007 MemSize  in  2  0 byte, 1 half, 2 word, 3 double (3 legal only when XLEN=64).
REQ-008 Address  in  XLEN  byte address.
REQ-009 StoreData  in  XLEN  store data, LSB-aligned.
REQ-010 StallM  out  1  hold pipeline.
REQ-011 LoadData  out  XLEN  load bytes right-justified to bit 0, upper bits zero; feeds writeback truncation.
REQ-012 LoadValid  out  1  one-cycle completion pulse.
REQ-013 AccessFault  out  1  one-cycle fault pulse, coincident with LoadValid.
REQ-014 BusReq  out  1; BusWe  out  1; BusAddr  out  XLEN (BYTES-aligned); BusWData  out  XLEN; BusByteEn  out  BYTES.
REQ-015 BusAck  in  1  transfer complete; BusRData  in  XLEN  read word, valid with BusAck.

Function
REQ-016 SHALL implement FSM IDLE, BEAT1, BEAT2, DONE.
REQ-017 IDLE: MemEn=1 SHALL latch MemWrite/MemSize/Address/StoreData, go BEAT1; StallM=MemEn (combinational).
REQ-018 BEAT1/BEAT2: BusReq=1, StallM=1; BusAddr/BusWe/BusWData/BusByteEn SHALL stay stable until BusAck sampled high.
REQ-019 BEAT1 on BusAck: to BEAT2 if access crosses a BYTES boundary (split), else to DONE.
REQ-020 BEAT2 on BusAck: to DONE; BusAddr = beat-1 address + BYTES.
REQ-021 DONE: StallM=0, LoadValid=1, BusReq=0; MemEn ignored; next state IDLE unconditionally.
REQ-022 Minimum latency, MemEn sampled cycle 0, ack in cycle 1: BusReq cycle 1, LoadValid cycle 2.
REQ-023 Offset o = Address mod BYTES; beat-1 BusByteEn = size mask shifted left o, truncated to BYTES; BusWData = StoreData << 8*o.
REQ-024 Beat 2: BusByteEn = remaining bytes in lanes from 0; BusWData = StoreData >> 8*(BYTES-o).
REQ-025 Loads: LoadData = (BusRData >> 8*o), beat-2 bytes OR'd in above them; bytes beyond size SHALL be zero.
REQ-026 LoadData SHALL be registered, updated only on DONE entry, held otherwise; stores leave it unchanged.
REQ-027 Wait counter SHALL clear on entering each beat and count cycles without BusAck; on reaching MAX_WAIT: AccessFault in DONE, LoadData=0, BusReq drops, no further beat.
REQ-028 BusAck outside BEAT1/BEAT2 SHALL be ignored.
REQ-029 MemSize=3 with XLEN=32 SHALL fault via DONE without a bus transfer.

Reset
REQ-030 reset SHALL force IDLE, counter 0, LoadData 0, BusReq/BusWe/LoadValid/AccessFault 0, BusAddr/BusWData/BusByteEn 0.
REQ-031 Reset mid-transaction SHALL abandon it; BusReq low the cycle after reset is sampled.

Configuration
REQ-032 Macro MISALIGNED_ACCESS_EN defined: misaligned accesses SHALL complete (single beat in-word, two beats when split).
REQ-033 Macro undefined: any address not a multiple of access size SHALL go IDLE->DONE with AccessFault=1, no BusReq, LoadData=0; BEAT2 unreachable.

Verification
REQ-034 XLEN=32, load word 0x100, ack cycle 1, BusRData=0xDEADBEEF -> BusByteEn=1111, LoadValid cycle 2, LoadData=0xDEADBEEF.
REQ-035 Load byte 0x103, BusRData=0x80FFFFFF -> BusAddr=0x100, BusByteEn=1000, LoadData=0x00000080.
REQ-036 Store half 0x102, StoreData=0x1234, ack after 3 wait cycles -> BusWData=0x12340000, BusByteEn=1100, stable all 4 cycles, StallM high until DONE.
REQ-037 MISALIGNED_ACCESS_EN on, load word 0x102, RData 0xAABBCCDD then 0x11223344 -> beats at 0x100 (1100), 0x104 (0011), LoadData=0x3344AABB; undefined -> AccessFault, no BusReq.
REQ-038 MAX_WAIT=4, never ack -> AccessFault+LoadValid after 4 wait cycles, LoadData=0, BusReq low in DONE.
REQ-039 reset asserted in BEAT1 -> next cycle IDLE, BusReq=0, all outputs at reset values.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit: M-stage load/store engine that turns one memory
// instruction into one or two bus beats, aligns store data into byte lanes,
// right-justifies load data and reports bus timeouts as access faults.
// Data width comes from `BIT_COUNT (32 or 64, default 32).
// Optional feature macro: MISALIGNED_ACCESS_EN. When defined, misaligned
// accesses complete (two beats if they straddle a bus word). When undefined,
// they fault immediately without touching the bus.

`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module memory_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemEn,
  input  logic                    MemWrite,
  input  logic [1:0]              MemSize,
  input  logic [`BIT_COUNT-1:0]   Address,
  input  logic [`BIT_COUNT-1:0]   StoreData,
  output logic                    StallM,
  output logic [`BIT_COUNT-1:0]   LoadData,
  output logic                    LoadValid,
  output logic                    AccessFault,
  output logic                    BusReq,
  output logic                    BusWe,
  output logic [`BIT_COUNT-1:0]   BusAddr,
  output logic [`BIT_COUNT-1:0]   BusWData,
  output logic [`BIT_COUNT/8-1:0] BusByteEn,
  input  logic                    BusAck,
  input  logic [`BIT_COUNT-1:0]   BusRData
);

  localparam int XLEN  = `BIT_COUNT;
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int CNTW  = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic              fault_q, fault_d;
  logic [CNTW-1:0]   waitCnt_q, waitCnt_d;
  logic [XLEN-1:0]   partial_q, partial_d;
  logic [XLEN-1:0]   loadData_q, loadData_d;
  logic [XLEN-1:0]   busAddr_q, busAddr_d;
  logic [XLEN-1:0]   busWData_q, busWData_d;
  logic [BYTES-1:0]  busByteEn_q, busByteEn_d;
  logic              busWe_q, busWe_d;

  logic              idle;
  logic [1:0]        curSize;
  logic [XLEN-1:0]   curAddr;
  logic [XLEN-1:0]   curData;
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   loShift;
  logic [OFFW+3:0]   hiShift;
  logic [2*BYTES-1:0] sizeMask;
  logic [2*BYTES-1:0] laneMask;
  logic [XLEN-1:0]   dataMask;
  logic              split;
  logic              illegalSize;
  logic              earlyFault;

  // Lane/shift geometry: from the live request while idle, from the latched request afterwards.
  always_comb begin
    idle     = (state_q == IDLE);
    curSize  = idle ? MemSize   : size_q;
    curAddr  = idle ? Address   : addr_q;
    curData  = idle ? StoreData : sdata_q;
    off      = curAddr[OFFW-1:0];
    loShift  = {off, 3'b000};
    hiShift  = {(OFFW+1)'(BYTES) - {1'b0, off}, 3'b000};
    case (curSize)
      2'd0:    sizeMask = (2*BYTES)'(1);
      2'd1:    sizeMask = (2*BYTES)'(3);
      2'd2:    sizeMask = (2*BYTES)'(15);
      default: sizeMask = (2*BYTES)'(255);
    endcase
    laneMask = sizeMask << off;
    split    = |laneMask[2*BYTES-1:BYTES];
    dataMask = '0;
    for (int i = 0; i < BYTES; i++) begin
      dataMask[i*8 +: 8] = {8{sizeMask[i]}};
    end
    illegalSize = (XLEN == 32) && (curSize == 2'd3);
  end

`ifdef MISALIGNED_ACCESS_EN
  assign earlyFault = illegalSize;
`else
  logic misAligned;

  // An access is misaligned when any offset bit below its size is set.
  always_comb begin
    misAligned = 1'b0;
    for (int i = 0; i < OFFW; i++) begin
      if (sizeMask[(2 << i) - 1] && off[i]) misAligned = 1'b1;
    end
  end

  assign earlyFault = illegalSize | misAligned;
`endif

  // Next-state, datapath updates and the combinational handshake outputs.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    fault_d     = fault_q;
    waitCnt_d   = waitCnt_q;
    partial_d   = partial_q;
    loadData_d  = loadData_q;
    busAddr_d   = busAddr_q;
    busWData_d  = busWData_q;
    busByteEn_d = busByteEn_q;
    busWe_d     = busWe_q;
    StallM      = 1'b0;
    BusReq      = 1'b0;
    LoadValid   = 1'b0;
    AccessFault = 1'b0;
    case (state_q)
      IDLE: begin
        StallM = MemEn;
        if (MemEn) begin
          write_d   = MemWrite;
          size_d    = MemSize;
          addr_d    = Address;
          sdata_d   = StoreData;
          waitCnt_d = '0;
          if (earlyFault) begin
            fault_d    = 1'b1;
            loadData_d = '0;
            state_d    = DONE;
          end else begin
            fault_d     = 1'b0;
            busAddr_d   = {curAddr[XLEN-1:OFFW], {OFFW{1'b0}}};
            busWData_d  = curData << loShift;
            busByteEn_d = laneMask[BYTES-1:0];
            busWe_d     = MemWrite;
            state_d     = BEAT1;
          end
        end
      end
      BEAT1: begin
        StallM = 1'b1;
        BusReq = 1'b1;
        if (BusAck) begin
          partial_d = BusRData >> loShift;
          if (split) begin
            waitCnt_d   = '0;
            busAddr_d   = busAddr_q + XLEN'(BYTES);
            busWData_d  = sdata_q >> hiShift;
            busByteEn_d = laneMask[2*BYTES-1:BYTES];
            state_d     = BEAT2;
          end else begin
            if (!write_q) loadData_d = (BusRData >> loShift) & dataMask;
            state_d = DONE;
          end
        end else if (waitCnt_q == CNTW'(MAX_WAIT - 1)) begin
          fault_d    = 1'b1;
          loadData_d = '0;
          state_d    = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      BEAT2: begin
        StallM = 1'b1;
        BusReq = 1'b1;
        if (BusAck) begin
          if (!write_q) loadData_d = (partial_q | (BusRData << hiShift)) & dataMask;
          state_d = DONE;
        end else if (waitCnt_q == CNTW'(MAX_WAIT - 1)) begin
          fault_d    = 1'b1;
          loadData_d = '0;
          state_d    = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      DONE: begin
        LoadValid   = 1'b1;
        AccessFault = fault_q;
        busAddr_d   = '0;
        busWData_d  = '0;
        busByteEn_d = '0;
        busWe_d     = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      sdata_q     <= '0;
      fault_q     <= 1'b0;
      waitCnt_q   <= '0;
      partial_q   <= '0;
      loadData_q  <= '0;
      busAddr_q   <= '0;
      busWData_q  <= '0;
      busByteEn_q <= '0;
      busWe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      fault_q     <= fault_d;
      waitCnt_q   <= waitCnt_d;
      partial_q   <= partial_d;
      loadData_q  <= loadData_d;
      busAddr_q   <= busAddr_d;
      busWData_q  <= busWData_d;
      busByteEn_q <= busByteEn_d;
      busWe_q     <= busWe_d;
    end
  end

  assign LoadData  = loadData_q;
  assign BusAddr   = busAddr_q;
  assign BusWData  = busWData_q;
  assign BusByteEn = busByteEn_q;
  assign BusWe     = busWe_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed bench for memory_access_unit (32-bit data).
// A byte-level transaction model predicts every cycle of each access; a
// single negedge process compares the DUT against those predictions, and
// hand-computed literals pin the model on the key scenarios.

`timescale 1ns/1ps

module tb_memory_access_unit;

  localparam int XL = 32;
  localparam int NB = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemEn;
  logic          MemWrite;
  logic [1:0]    MemSize;
  logic [XL-1:0] Address;
  logic [XL-1:0] StoreData;
  logic          StallM;
  logic [XL-1:0] LoadData;
  logic          LoadValid;
  logic          AccessFault;
  logic          BusReq;
  logic          BusWe;
  logic [XL-1:0] BusAddr;
  logic [XL-1:0] BusWData;
  logic [NB-1:0] BusByteEn;
  logic          BusAck;
  logic [XL-1:0] BusRData;

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations written by the stimulus, read by the compare process.
  logic          chkEn = 1'b0;
  logic          expStallM = 1'b0;
  logic          expBusReq = 1'b0;
  logic          expLoadValid = 1'b0;
  logic          expFault = 1'b0;
  logic          expZeroBus = 1'b0;
  logic          expWe = 1'b0;
  logic          expIsStore = 1'b0;
  logic [31:0]   expLoadData = '0;
  logic [31:0]   expAddr = '0;
  logic [31:0]   expWD = '0;
  logic [3:0]    expBE = '0;
  int            expBeat = 0;
  logic [31:0]   capAddr [2];
  logic [31:0]   capWD [2];
  logic [3:0]    capBE [2];

  memory_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemWrite(MemWrite),
    .MemSize(MemSize), .Address(Address), .StoreData(StoreData),
    .StallM(StallM), .LoadData(LoadData), .LoadValid(LoadValid),
    .AccessFault(AccessFault), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusByteEn(BusByteEn),
    .BusAck(BusAck), .BusRData(BusRData)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT against the model each cycle, mid-way between rising edges.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("StallM", 32'(StallM), 32'(expStallM));
      checkOutput("BusReq", 32'(BusReq), 32'(expBusReq));
      checkOutput("LoadValid", 32'(LoadValid), 32'(expLoadValid));
      checkOutput("AccessFault", 32'(AccessFault), 32'(expFault));
      checkOutput("LoadData", LoadData, expLoadData);
      if (expBusReq) begin
        checkOutput("BusAddr", BusAddr, expAddr);
        checkOutput("BusByteEn", 32'(BusByteEn), 32'(expBE));
        checkOutput("BusWe", 32'(BusWe), 32'(expWe));
        if (expIsStore) checkOutput("BusWData", BusWData, expWD);
        capAddr[expBeat] = BusAddr;
        capWD[expBeat]   = BusWData;
        capBE[expBeat]   = BusByteEn;
      end
      if (expZeroBus) begin
        checkOutput("rstBusAddr", BusAddr, 32'h0);
        checkOutput("rstBusWData", BusWData, 32'h0);
        checkOutput("rstBusByteEn", 32'(BusByteEn), 32'h0);
        checkOutput("rstBusWe", 32'(BusWe), 32'h0);
      end
    end
  end

  // One complete access: the byte-level model predicts lanes and load bytes,
  // then the bus side is played out with the given per-beat wait counts.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] sdata, input int w0, input int w1,
                               input logic [31:0] rd0, input logic [31:0] rd1);
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    int          wt [2];
    logic [31:0] ld;
    logic [31:0] base;
    logic        legal;
    logic        timedOut;
    int          n, a, bi, lane, nbeats;
    rd[0] = rd0; rd[1] = rd1; wt[0] = w0; wt[1] = w1;
    be[0] = '0; be[1] = '0; wd[0] = '0; wd[1] = '0; ld = '0;
    n = 1 << sz;
    legal = (sz != 2'd3);
`ifndef MISALIGNED_ACCESS_EN
    if ((addr % n) != 0) legal = 1'b0;
`endif
    base = addr & ~32'h3;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        a    = int'(addr) + i;
        bi   = (a - int'(base)) / NB;
        lane = a % NB;
        be[bi][lane]          = 1'b1;
        wd[bi][lane*8 +: 8]   = sdata[i*8 +: 8];
        ld[i*8 +: 8]          = rd[bi][lane*8 +: 8];
      end
    end
    nbeats = (be[1] != 4'b0) ? 2 : 1;

    nextCycle();
    MemEn = 1'b1; MemWrite = wr; MemSize = sz; Address = addr; StoreData = sdata; BusAck = 1'b0;
    expStallM = 1'b1; expBusReq = 1'b0; expLoadValid = 1'b0; expFault = 1'b0; expIsStore = wr;
    timedOut = 1'b0;
    if (legal) begin
      for (int b = 0; b < nbeats; b++) begin
        for (int c = 0; c < MW; c++) begin
          nextCycle();
          expBusReq = 1'b1; expStallM = 1'b1; expBeat = b;
          expAddr = base + 32'(b * NB); expBE = be[b]; expWD = wd[b]; expWe = wr;
          if (c == wt[b]) begin
            BusAck = 1'b1; BusRData = rd[b];
            break;
          end
          BusAck = 1'b0; BusRData = $urandom;
          if (c == MW - 1) timedOut = 1'b1;
        end
        if (timedOut) break;
      end
    end

    nextCycle();
    BusAck = 1'b1; BusRData = $urandom;
    expBusReq = 1'b0; expStallM = 1'b0; expLoadValid = 1'b1;
    expFault = !legal || timedOut;
    if (expFault) expLoadData = '0;
    else if (!wr) expLoadData = ld;

    nextCycle();
    MemEn = 1'b0;
    expLoadValid = 1'b0; expFault = 1'b0; expStallM = 1'b0;
    nextCycle();
    BusAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemEn = 1'b0; MemWrite = 1'b0; MemSize = 2'd0;
    Address = '0; StoreData = '0; BusAck = 1'b0; BusRData = '0;
    nextCycle();
    chkEn = 1'b1; expZeroBus = 1'b1;
    checkOutput("reset_LoadData", LoadData, 32'h0);
    checkOutput("reset_BusReq", 32'(BusReq), 32'h0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    expZeroBus = 1'b0;

    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0);
    checkOutput("lw_data", LoadData, 32'hDEADBEEF);
    checkOutput("lw_be", 32'(capBE[0]), 32'hF);
    checkOutput("lw_addr", capAddr[0], 32'h100);

    applyStimulus(1'b0, 2'd0, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF, 32'h0);
    checkOutput("lb_addr", capAddr[0], 32'h100);
    checkOutput("lb_be", 32'(capBE[0]), 32'h8);
    checkOutput("lb_data", LoadData, 32'h00000080);

    applyStimulus(1'b1, 2'd1, 32'h102, 32'h00001234, 3, 0, 32'h0, 32'h0);
    checkOutput("sh_wdata", capWD[0], 32'h12340000);
    checkOutput("sh_be", 32'(capBE[0]), 32'hC);
    checkOutput("sh_keep", LoadData, 32'h00000080);

    applyStimulus(1'b0, 2'd2, 32'h102, 32'h0, 0, 0, 32'hAABBCCDD, 32'h11223344);
`ifdef MISALIGNED_ACCESS_EN
    checkOutput("lw_split_data", LoadData, 32'h3344AABB);
    checkOutput("lw_split_be1", 32'(capBE[0]), 32'hC);
    checkOutput("lw_split_addr2", capAddr[1], 32'h104);
    checkOutput("lw_split_be2", 32'(capBE[1]), 32'h3);
`else
    checkOutput("lw_misal_data", LoadData, 32'h0);
`endif

    applyStimulus(1'b0, 2'd1, 32'h106, 32'h0, 1, 0, 32'hCAFE1234, 32'h0);
    checkOutput("lh_data", LoadData, 32'h0000CAFE);

    applyStimulus(1'b0, 2'd2, 32'h200, 32'h0, 99, 0, 32'h0, 32'h0);
    checkOutput("timeout_data", LoadData, 32'h0);

    applyStimulus(1'b1, 2'd0, 32'h101, 32'h000000A5, 0, 0, 32'h0, 32'h0);
    checkOutput("sb_wdata", capWD[0], 32'h0000A500);
    checkOutput("sb_be", 32'(capBE[0]), 32'h2);

    applyStimulus(1'b0, 2'd2, 32'h10, 32'h0, 2, 0, 32'h01234567, 32'h0);
    checkOutput("lw_wait_data", LoadData, 32'h01234567);

    applyStimulus(1'b0, 2'd3, 32'h8, 32'h0, 0, 0, 32'h55555555, 32'h0);
    checkOutput("ld_illegal_data", LoadData, 32'h0);

    applyStimulus(1'b0, 2'd0, 32'h20, 32'h0, 0, 0, 32'h123456EE, 32'h0);
    checkOutput("lb0_data", LoadData, 32'h000000EE);

    applyStimulus(1'b0, 2'd1, 32'h103, 32'h0, 1, 2, 32'h55667788, 32'h99AABBCC);
`ifdef MISALIGNED_ACCESS_EN
    checkOutput("lh_split_data", LoadData, 32'h0000CC55);
`else
    checkOutput("lh_misal_data", LoadData, 32'h0);
`endif

    applyStimulus(1'b0, 2'd2, 32'h40, 32'h0, 0, 0, 32'h600DF00D, 32'h0);

    // Reset while the first beat is outstanding.
    nextCycle();
    MemEn = 1'b1; MemWrite = 1'b0; MemSize = 2'd2; Address = 32'h300; BusAck = 1'b0;
    expStallM = 1'b1; expBusReq = 1'b0; expIsStore = 1'b0;
    nextCycle();
    reset = 1'b1;
    expBusReq = 1'b1; expStallM = 1'b1; expBeat = 0;
    expAddr = 32'h300; expBE = 4'hF; expWe = 1'b0;
    nextCycle();
    reset = 1'b0; MemEn = 1'b0;
    expBusReq = 1'b0; expStallM = 1'b0; expLoadData = '0; expZeroBus = 1'b1;
    nextCycle();
    checkOutput("midrst_BusReq", 32'(BusReq), 32'h0);
    checkOutput("midrst_LoadData", LoadData, 32'h0);
    nextCycle();
    expZeroBus = 1'b0;

    applyStimulus(1'b0, 2'd0, 32'h1, 32'h0, 0, 0, 32'h0000AB00, 32'h0);
    checkOutput("post_rst_lb", LoadData, 32'h000000AB);

    nextCycle();
    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
